// File: rtl/shift_defs.sv
// Shared mode and state encodings for the shift-right sequencer.
package shift_defs;

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_ROR = 2'b01,
        MODE_RCR = 2'b10,
        MODE_ASR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_right_step.sv
// One single-bit right-shift step; the mode picks the incoming MSB.
module shift_right_step
    import shift_defs::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             carry,
    input  mode_e            mode,
    output logic [WIDTH-1:0] q,
    output logic             sout
);

    logic msb;

    // 4:1 MSB mux, lower bits always move down by one
    always_comb begin
        msb = 1'b0;
        unique case (mode)
            MODE_LSR: msb = 1'b0;
            MODE_ROR: msb = d[0];
            MODE_RCR: msb = carry;
            MODE_ASR: msb = d[WIDTH-1];
        endcase
        q    = {msb, d[WIDTH-1:1]};
        sout = d[0];
    end

endmodule

// File: rtl/shift_right_sequencer.sv
// Multi-cycle right shifter: latches an operand on start, applies one
// single-bit step per clock, then pulses done with result and carry-out.
module shift_right_sequencer
    import shift_defs::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic             cin,
    input  logic             sel1,
    input  logic             sel0,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    mode_e            mode_q, mode_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             busy_d, done_d;
    logic [WIDTH-1:0] step_data;
    logic             step_out;

    shift_right_step #(.WIDTH(WIDTH)) u_step (
        .d     (data_q),
        .carry (carry_q),
        .mode  (mode_q),
        .q     (step_data),
        .sout  (step_out)
    );

    // State, datapath and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            mode_q  <= MODE_LSR;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state, datapath update; busy/done precomputed from next state
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d  = x;
                    carry_d = cin;
                    mode_d  = mode_e'({sel1, sel0});
                    cnt_d   = amount;
                    state_d = (amount == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d  = step_data;
                carry_d = step_out;
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign f    = data_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_shift_right_sequencer.sv
// Self-checking bench: directed table, random ops against an arithmetic
// reference model, and reset corner sequences.
module tb_shift_right_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] x;
    logic       cin;
    logic       sel1;
    logic       sel0;
    logic [2:0] amount;
    logic [7:0] f;
    logic       cout;
    logic       busy;
    logic       done;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] xv;
        logic       c;
        int         amt;
        logic       hold;
        logic [7:0] ef;
        logic       ec;
    } vec_t;

    vec_t vecs[6];

    shift_right_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x      (x),
        .cin    (cin),
        .sel1   (sel1),
        .sel0   (sel0),
        .amount (amount),
        .f      (f),
        .cout   (cout),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole-operation result computed directly from shift arithmetic
    function automatic void model(input logic [1:0] m, input logic [7:0] xv, input logic c,
                                  input int n, output logic [7:0] ef, output logic ec);
        logic [15:0]      xx;
        logic [8:0]       v;
        logic [17:0]      vv;
        logic signed [7:0] xs;
        ef = xv;
        ec = c;
        case (m)
            2'b00: ef = xv >> n;
            2'b01: begin xx = {xv, xv}; ef = 8'(xx >> n); end
            2'b10: begin v = {c, xv}; vv = {v, v}; v = 9'(vv >> n); ef = v[7:0]; ec = v[8]; end
            default: begin xs = xv; ef = 8'(xs >>> n); end
        endcase
        if (m != 2'b10 && n != 0) ec = xv[n-1];
    endfunction

    task automatic run_op(input string name, input logic [1:0] m, input logic [7:0] xv,
                          input logic c, input int n, input logic hold,
                          input logic [7:0] ef, input logic ec);
        int edges;
        bit got;
        @(negedge clk);
        {sel1, sel0} = m;
        x = xv;
        cin = c;
        amount = 3'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        check({name, " busy_rise"}, 32'(busy), 32'd1);
        start = hold;
        x = 8'($urandom);
        cin = 1'($urandom);
        {sel1, sel0} = 2'($urandom);
        amount = 3'($urandom);
        edges = 0;
        got = 0;
        while (!got && edges <= 20) begin
            if (done) got = 1;
            else begin
                @(posedge clk);
                #1;
                edges++;
            end
        end
        check({name, " latency"}, got ? 32'(edges) : 32'd999, 32'(n));
        check({name, " f"}, 32'(f), 32'(ef));
        check({name, " cout"}, 32'(cout), 32'(ec));
        check({name, " busy_in_done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({name, " done_fall"}, 32'(done), 32'd0);
        check({name, " busy_fall"}, 32'(busy), 32'd0);
        check({name, " f_hold"}, 32'(f), 32'(ef));
        start = 1'b0;
    endtask

    initial begin
        logic [1:0] m;
        logic [7:0] xv;
        logic [7:0] ef;
        logic       c;
        logic       ec;
        int         n;

        vecs[0] = '{2'b00, 8'b1011_0110, 1'b0, 3, 1'b0, 8'b0001_0110, 1'b1};
        vecs[1] = '{2'b11, 8'b1001_0000, 1'b0, 2, 1'b0, 8'b1110_0100, 1'b0};
        vecs[2] = '{2'b10, 8'b0000_0011, 1'b1, 2, 1'b0, 8'b1100_0000, 1'b1};
        vecs[3] = '{2'b01, 8'b1000_0001, 1'b0, 7, 1'b0, 8'b0000_0011, 1'b0};
        vecs[4] = '{2'b00, 8'h5A,        1'b1, 0, 1'b0, 8'b0101_1010, 1'b1};
        vecs[5] = '{2'b01, 8'hC3,        1'b1, 5, 1'b1, 8'h1E,        1'b0};

        // Reset held with random inputs and start toggling
        rst_n = 1'b0;
        start = 1'b0;
        x = '0; cin = 1'b0; sel1 = 1'b0; sel0 = 1'b0; amount = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b1;
            x = 8'($urandom);
            cin = 1'($urandom);
            {sel1, sel0} = 2'($urandom);
            amount = 3'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("reset_hold%0d", i), 32'({f, cout, busy, done}), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].xv, vecs[i].c,
                   vecs[i].amt, vecs[i].hold, vecs[i].ef, vecs[i].ec);
        end

        // Reset in the middle of a SHIFT phase
        @(negedge clk);
        {sel1, sel0} = 2'b11;
        x = 8'hFF;
        cin = 1'b1;
        amount = 3'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_clear", 32'({f, cout, busy, done}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_reset", 2'b00, 8'hF0, 1'b0, 4, 1'b0, 8'h0F, 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            m  = 2'($urandom);
            xv = 8'($urandom);
            c  = 1'($urandom);
            n  = int'($urandom_range(0, 7));
            model(m, xv, c, n, ef, ec);
            run_op($sformatf("rnd%0d", i), m, xv, c, n, 1'($urandom), ef, ec);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
